bus_arbiter: RTL

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_arbiter.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/bus_arbiter.sv
// bus_arbiter: three-port round-robin arbiter onto one shared bus.
// A transfer is held on the bus until i_bus_ready. The granted port must then
// drop its request before the arbiter re-arbitrates.
// Optional watchdog abort: define BUS_ARBITER_TIMEOUT_EN.
module bus_arbiter #(
  parameter int unsigned TIMEOUT    = 1023,
  parameter logic [31:0] ERROR_DATA = 32'hDEADBEEF
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_pa_request,
  input  logic        i_pb_request,
  input  logic        i_pc_request,
  input  logic        i_pa_rw,
  input  logic        i_pb_rw,
  input  logic        i_pc_rw,
  input  logic [31:0] i_pa_address,
  input  logic [31:0] i_pb_address,
  input  logic [31:0] i_pc_address,
  input  logic [31:0] i_pa_wdata,
  input  logic [31:0] i_pb_wdata,
  input  logic [31:0] i_pc_wdata,
  output logic        o_pa_ready,
  output logic        o_pb_ready,
  output logic        o_pc_ready,
  output logic [31:0] o_pa_rdata,
  output logic [31:0] o_pb_rdata,
  output logic [31:0] o_pc_rdata,
  output logic        o_bus_request,
  output logic        o_bus_rw,
  output logic [31:0] o_bus_address,
  output logic [31:0] o_bus_wdata,
  input  logic        i_bus_ready,
  input  logic [31:0] i_bus_rdata,
  output logic [1:0]  o_grant,
  output logic        o_timeout
);

  typedef enum logic [1:0] {StIdle, StAccess, StRelease} state_t;

  localparam logic [1:0] GrantNone = 2'd3;

  state_t           state_q, state_d;
  logic [1:0]       last_q, last_d;
  logic [1:0]       grant_q, grant_d;
  logic             bus_req_q, bus_req_d;
  logic             bus_rw_q, bus_rw_d;
  logic [31:0]      bus_addr_q, bus_addr_d;
  logic [31:0]      bus_wdata_q, bus_wdata_d;
  logic [2:0]       ready_q, ready_d;
  logic [2:0][31:0] rdata_q, rdata_d;

  logic [2:0]       req;
  logic [2:0]       rw;
  logic [2:0][31:0] addr;
  logic [2:0][31:0] wdata;
  logic             pick_valid;
  logic [1:0]       pick;
  logic [1:0]       cand;

  assign req   = {i_pc_request, i_pb_request, i_pa_request};
  assign rw    = {i_pc_rw, i_pb_rw, i_pa_rw};
  assign addr  = {i_pc_address, i_pb_address, i_pa_address};
  assign wdata = {i_pc_wdata, i_pb_wdata, i_pa_wdata};

`ifdef BUS_ARBITER_TIMEOUT_EN
  logic [31:0] wd_q;
  logic        timeout_q, timeout_d;
`endif

  // Round-robin pick: first requesting port after the last one served.
  always_comb begin
    pick_valid = 1'b0;
    pick       = 2'd0;
    cand       = 2'd0;
    for (int k = 1; k <= 3; k++) begin
      cand = 2'((int'(last_q) + k) % 3);
      if (!pick_valid && req[cand]) begin
        pick_valid = 1'b1;
        pick       = cand;
      end
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    grant_d     = grant_q;
    bus_req_d   = bus_req_q;
    bus_rw_d    = bus_rw_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    ready_d     = 3'b000;
    rdata_d     = rdata_q;
`ifdef BUS_ARBITER_TIMEOUT_EN
    timeout_d   = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        if (pick_valid) begin
          grant_d     = pick;
          bus_req_d   = 1'b1;
          bus_rw_d    = rw[pick];
          bus_addr_d  = addr[pick];
          bus_wdata_d = wdata[pick];
          state_d     = StAccess;
        end
      end
      StAccess: begin
        if (i_bus_ready) begin
          ready_d[grant_q] = 1'b1;
          // Writes leave the port's read-data register untouched.
          if (!bus_rw_q) rdata_d[grant_q] = i_bus_rdata;
          bus_req_d = 1'b0;
          last_d    = grant_q;
          state_d   = StRelease;
        end
`ifdef BUS_ARBITER_TIMEOUT_EN
        else if (wd_q == TIMEOUT - 1) begin
          ready_d[grant_q] = 1'b1;
          timeout_d        = 1'b1;
          if (!bus_rw_q) rdata_d[grant_q] = ERROR_DATA;
          bus_req_d = 1'b0;
          last_d    = grant_q;
          state_d   = StRelease;
        end
`endif
      end
      StRelease: begin
        // Wait for the served port to drop so a held request is not served twice.
        if (!req[grant_q]) begin
          grant_d = GrantNone;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q     <= StIdle;
      last_q      <= 2'd2;
      grant_q     <= GrantNone;
      bus_req_q   <= 1'b0;
      bus_rw_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      ready_q     <= 3'b000;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      grant_q     <= grant_d;
      bus_req_q   <= bus_req_d;
      bus_rw_q    <= bus_rw_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      ready_q     <= ready_d;
      rdata_q     <= rdata_d;
    end
  end

`ifdef BUS_ARBITER_TIMEOUT_EN
  // Watchdog counts cycles spent in ACCESS; zero on every ACCESS entry.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_q      <= (state_q == StAccess) ? wd_q + 32'd1 : 32'd0;
      timeout_q <= timeout_d;
    end
  end

  assign o_timeout = timeout_q;
`else
  assign o_timeout = 1'b0;
`endif

  assign o_pa_ready    = ready_q[0];
  assign o_pb_ready    = ready_q[1];
  assign o_pc_ready    = ready_q[2];
  assign o_pa_rdata    = rdata_q[0];
  assign o_pb_rdata    = rdata_q[1];
  assign o_pc_rdata    = rdata_q[2];
  assign o_bus_request = bus_req_q;
  assign o_bus_rw      = bus_rw_q;
  assign o_bus_address = bus_addr_q;
  assign o_bus_wdata   = bus_wdata_q;
  assign o_grant       = grant_q;

endmodule
